// File: rtl/cpu_pkg.sv
// cpu_pkg: shared RV32I control types, opcodes and ALU operation codes.
package cpu_pkg;
    localparam int CTRL_BE_W = 4;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [1:0] ALU_OP_ADD = 2'b00;
    localparam logic [1:0] ALU_OP_BR  = 2'b01;
    localparam logic [1:0] ALU_OP_R   = 2'b10;
    localparam logic [1:0] ALU_OP_I   = 2'b11;
    typedef struct packed {
        logic                 branch;
        logic [2:0]           br_f3;
        logic                 jump;
        logic                 jalr;
        logic                 reg_write;
        logic                 mem_read;
        logic                 mem_to_reg;
        logic [CTRL_BE_W-1:0] mem_write;
        logic [1:0]           alu_op;
        logic                 alu_src;
        logic                 lui;
        logic                 auipc;
        logic                 illegal;
    } ctrl_t;
endpackage

// File: rtl/rv_decode.sv
// rv_decode: combinational RV32I decode into control bundle, register indices and immediate.
module rv_decode import cpu_pkg::*; #(
    parameter int XLEN     = 32,
    parameter int MEM_BE_W = 4
) (
    input  logic [31:0]     instr_i,
    output ctrl_t           ctrl_o,
    output logic [4:0]      rs1_o,
    output logic [4:0]      rs2_o,
    output logic [4:0]      rd_o,
    output logic [XLEN-1:0] imm_o,
    output logic            use_rs1_o,
    output logic            use_rs2_o
);
    logic [6:0]          w_opc;
    logic [2:0]          w_f3;
    logic [MEM_BE_W-1:0] w_be;
    logic [XLEN-1:0]     w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    assign w_opc     = instr_i[6:0];
    assign w_f3      = instr_i[14:12];
    assign rs1_o     = instr_i[19:15];
    assign rs2_o     = instr_i[24:20];
    assign rd_o      = ctrl_o.reg_write ? instr_i[11:7] : 5'd0;
    assign use_rs1_o = !(w_opc == OPC_LUI || w_opc == OPC_AUIPC || w_opc == OPC_JAL);
    assign use_rs2_o = w_opc == OPC_OP || w_opc == OPC_STORE || w_opc == OPC_BRANCH;
    assign w_be      = w_f3 == 3'd0 ? MEM_BE_W'(1) : w_f3 == 3'd1 ? MEM_BE_W'(3) : '1;
    assign w_imm_i   = XLEN'($signed(instr_i[31:20]));
    assign w_imm_s   = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
    assign w_imm_b   = XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0}));
    assign w_imm_u   = XLEN'($signed({instr_i[31:12], 12'h000}));
    assign w_imm_j   = XLEN'($signed({instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0}));
    always_comb begin
        ctrl_o = '0;
        imm_o  = '0;
        case (w_opc)
            OPC_OP: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_op    = ALU_OP_R;
            end
            OPC_OP_IMM: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_op    = ALU_OP_I;
                ctrl_o.alu_src   = 1'b1;
                imm_o            = w_imm_i;
            end
            OPC_LOAD: begin
                ctrl_o.mem_read   = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.alu_op     = ALU_OP_ADD;
                ctrl_o.alu_src    = 1'b1;
                imm_o             = w_imm_i;
            end
            OPC_STORE: begin
                ctrl_o.mem_write = w_be;
                imm_o            = w_imm_s;
            end
            OPC_BRANCH: begin
                // funct3 010/011 are unassigned branch encodings
                ctrl_o.illegal = w_f3[2:1] == 2'b01;
                ctrl_o.branch  = w_f3[2:1] != 2'b01;
                ctrl_o.br_f3   = w_f3[2:1] != 2'b01 ? w_f3 : 3'd0;
                ctrl_o.alu_op  = w_f3[2:1] != 2'b01 ? ALU_OP_BR : ALU_OP_ADD;
                imm_o          = w_f3[2:1] != 2'b01 ? w_imm_b : '0;
            end
            OPC_JAL: begin
                ctrl_o.jump      = 1'b1;
                ctrl_o.reg_write = 1'b1;
                imm_o            = w_imm_j;
            end
            OPC_JALR: begin
                ctrl_o.jump      = 1'b1;
                ctrl_o.jalr      = 1'b1;
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_src   = 1'b1;
                imm_o            = w_imm_i;
            end
            OPC_LUI: begin
                ctrl_o.lui       = 1'b1;
                ctrl_o.reg_write = 1'b1;
                imm_o            = w_imm_u;
            end
            OPC_AUIPC: begin
                ctrl_o.auipc     = 1'b1;
                ctrl_o.reg_write = 1'b1;
                imm_o            = w_imm_u;
            end
            default: ctrl_o.illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/ctrl_decode_pipe.sv
// ctrl_decode_pipe: registered RV32I control decoder with valid/ready handshake, load-use interlock and stall counter.
module ctrl_decode_pipe import cpu_pkg::*; #(
    parameter int XLEN        = 32,
    parameter int MEM_BE_W    = 4,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [31:0]            instr_i,
    input  logic                   instr_valid_i,
    output logic                   in_ready_o,
    input  logic                   flush_i,
    input  logic                   ex_mem_read_i,
    input  logic [4:0]             ex_rd_i,
    input  logic                   out_ready_i,
    output logic                   valid_o,
    output ctrl_t                  ctrl_o,
    output logic [4:0]             rs1_o,
    output logic [4:0]             rs2_o,
    output logic [4:0]             rd_o,
    output logic [XLEN-1:0]        imm_o,
    output logic [STALL_CNT_W-1:0] stall_cnt_o
);
    ctrl_t                  w_ctrl, r_ctrl;
    logic [4:0]             w_rs1, w_rs2, w_rd, r_rs1, r_rs2, r_rd;
    logic [XLEN-1:0]        w_imm, r_imm;
    logic                   w_use_rs1, w_use_rs2, w_hazard, w_adv, r_valid;
    logic [STALL_CNT_W-1:0] r_cnt;
    rv_decode #(.XLEN(XLEN), .MEM_BE_W(MEM_BE_W)) u_dec (
        .instr_i   (instr_i),
        .ctrl_o    (w_ctrl),
        .rs1_o     (w_rs1),
        .rs2_o     (w_rs2),
        .rd_o      (w_rd),
        .imm_o     (w_imm),
        .use_rs1_o (w_use_rs1),
        .use_rs2_o (w_use_rs2)
    );
    assign w_adv    = ~r_valid | out_ready_i;
    assign w_hazard = instr_valid_i & ex_mem_read_i & (ex_rd_i != 5'd0) &
                      ((w_use_rs1 & (ex_rd_i == w_rs1)) | (w_use_rs2 & (ex_rd_i == w_rs2)));
    assign in_ready_o  = ~flush_i & ~w_hazard & w_adv;
    assign valid_o     = r_valid;
    assign ctrl_o      = r_ctrl;
    assign rs1_o       = r_rs1;
    assign rs2_o       = r_rs2;
    assign rd_o        = r_rd;
    assign imm_o       = r_imm;
    assign stall_cnt_o = r_cnt;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_rs1   <= '0;
            r_rs2   <= '0;
            r_rd    <= '0;
            r_imm   <= '0;
            r_cnt   <= '0;
        end else begin
            if (flush_i) begin
                r_valid <= 1'b0;
            end else if (w_hazard & w_adv) begin
                r_valid <= 1'b0;
                r_ctrl  <= '0;
            end else if (instr_valid_i & in_ready_o) begin
                r_valid <= 1'b1;
                r_ctrl  <= w_ctrl;
                r_rs1   <= w_rs1;
                r_rs2   <= w_rs2;
                r_rd    <= w_rd;
                r_imm   <= w_imm;
            end else if (r_valid & out_ready_i) begin
                r_valid <= 1'b0;
            end
            if (w_hazard & ~flush_i & ~&r_cnt)
                r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// tb_ctrl_decode_pipe: directed and randomized checks of ctrl_decode_pipe against a behavioural model.
module tb_ctrl_decode_pipe;
    import cpu_pkg::*;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1, instr_valid_i = 1'b0, flush_i = 1'b0, ex_mem_read_i = 1'b0, out_ready_i = 1'b0;
    logic [31:0] instr_i = 32'h0;
    logic [4:0]  ex_rd_i = 5'd0;
    logic        in_ready_o, valid_o, in_ready2, valid2;
    ctrl_t       ctrl_o, ctrl2;
    logic [4:0]  rs1_o, rs2_o, rd_o, rs1_2, rs2_2, rd_2;
    logic [31:0] imm_o, imm2;
    logic [15:0] stall_cnt_o;
    logic [1:0]  cnt2;
    int          checks = 0, errors = 0;
    bit          live = 0;
    bit          m_valid = 0;
    ctrl_t       m_ctrl = '0;
    logic [4:0]  m_rs1 = 0, m_rs2 = 0, m_rd = 0;
    logic [31:0] m_imm = 0;
    int          m_cnt = 0, m_cnt2 = 0;
    localparam logic [31:0] ADD_3_1_2 = 32'h002081B3;
    localparam logic [31:0] ADD_6_5_1 = 32'h00128333;
    localparam logic [31:0] SW_2_8_1  = 32'h0020A423;
    localparam logic [31:0] BEQ_1_2   = 32'h00208863;

    always #5 clk_i = ~clk_i;

    ctrl_decode_pipe dut (
        .clk_i(clk_i), .rst_i(rst_i), .instr_i(instr_i), .instr_valid_i(instr_valid_i),
        .in_ready_o(in_ready_o), .flush_i(flush_i), .ex_mem_read_i(ex_mem_read_i), .ex_rd_i(ex_rd_i),
        .out_ready_i(out_ready_i), .valid_o(valid_o), .ctrl_o(ctrl_o), .rs1_o(rs1_o), .rs2_o(rs2_o),
        .rd_o(rd_o), .imm_o(imm_o), .stall_cnt_o(stall_cnt_o)
    );
    ctrl_decode_pipe #(.STALL_CNT_W(2)) dut2 (
        .clk_i(clk_i), .rst_i(rst_i), .instr_i(instr_i), .instr_valid_i(instr_valid_i),
        .in_ready_o(in_ready2), .flush_i(flush_i), .ex_mem_read_i(ex_mem_read_i), .ex_rd_i(ex_rd_i),
        .out_ready_i(out_ready_i), .valid_o(valid2), .ctrl_o(ctrl2), .rs1_o(rs1_2), .rs2_o(rs2_2),
        .rd_o(rd_2), .imm_o(imm2), .stall_cnt_o(cnt2)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void ref_dec(input logic [31:0] w, output ctrl_t c, output logic [31:0] imm,
                                    output bit u1, output bit u2);
        logic [6:0] op;
        logic [2:0] f3;
        op  = w[6:0];
        f3  = w[14:12];
        c   = '0;
        imm = 32'h0;
        u1  = !(op == OPC_LUI || op == OPC_AUIPC || op == OPC_JAL);
        u2  = op == OPC_OP || op == OPC_STORE || op == OPC_BRANCH;
        case (op)
            OPC_OP:     begin c.reg_write = 1; c.alu_op = 2'b10; end
            OPC_OP_IMM: begin c.reg_write = 1; c.alu_op = 2'b11; c.alu_src = 1; imm = 32'($signed(w[31:20])); end
            OPC_LOAD:   begin c.mem_read = 1; c.mem_to_reg = 1; c.reg_write = 1; c.alu_src = 1; imm = 32'($signed(w[31:20])); end
            OPC_STORE:  begin
                c.mem_write = (f3 == 0) ? 4'b0001 : (f3 == 1) ? 4'b0011 : 4'b1111;
                imm = 32'($signed({w[31:25], w[11:7]}));
            end
            OPC_BRANCH: begin
                if (f3 == 3'd2 || f3 == 3'd3) c.illegal = 1;
                else begin
                    c.branch = 1; c.br_f3 = f3; c.alu_op = 2'b01;
                    imm = 32'($signed({w[31], w[7], w[30:25], w[11:8]})) << 1;
                end
            end
            OPC_JAL:    begin c.jump = 1; c.reg_write = 1; imm = 32'($signed({w[31], w[19:12], w[20], w[30:21]})) << 1; end
            OPC_JALR:   begin c.jump = 1; c.jalr = 1; c.reg_write = 1; c.alu_src = 1; imm = 32'($signed(w[31:20])); end
            OPC_LUI:    begin c.lui = 1; c.reg_write = 1; imm = w & 32'hFFFFF000; end
            OPC_AUIPC:  begin c.auipc = 1; c.reg_write = 1; imm = w & 32'hFFFFF000; end
            default:    c.illegal = 1;
        endcase
    endfunction

    // Check outputs at the falling edge, then advance the model across the next rising edge.
    task automatic step();
        ctrl_t c;
        logic [31:0] imm;
        bit u1, u2, hz, adv, rdy, n_valid;
        ctrl_t n_ctrl;
        logic [4:0] n_rs1, n_rs2, n_rd;
        logic [31:0] n_imm;
        int n_cnt, n_cnt2;
        @(negedge clk_i);
        ref_dec(instr_i, c, imm, u1, u2);
        hz  = instr_valid_i && ex_mem_read_i && ex_rd_i != 0 &&
              ((u1 && ex_rd_i == instr_i[19:15]) || (u2 && ex_rd_i == instr_i[24:20]));
        adv = !m_valid || out_ready_i;
        rdy = !flush_i && !hz && adv;
        if (live) begin
            chk("in_ready", 64'(in_ready_o), 64'(rdy));
            chk("in_ready_w2", 64'(in_ready2), 64'(rdy));
            chk("valid", 64'(valid_o), 64'(m_valid));
            chk("valid_w2", 64'(valid2), 64'(m_valid));
            chk("stall_cnt", 64'(stall_cnt_o), 64'(m_cnt));
            chk("stall_cnt_w2", 64'(cnt2), 64'(m_cnt2));
            if (m_valid) begin
                chk("ctrl", 64'(ctrl_o), 64'(m_ctrl));
                chk("rs1", 64'(rs1_o), 64'(m_rs1));
                chk("rs2", 64'(rs2_o), 64'(m_rs2));
                chk("rd", 64'(rd_o), 64'(m_rd));
                chk("imm", 64'(imm_o), 64'(m_imm));
            end
        end
        n_valid = m_valid; n_ctrl = m_ctrl; n_rs1 = m_rs1; n_rs2 = m_rs2; n_rd = m_rd; n_imm = m_imm;
        n_cnt = m_cnt; n_cnt2 = m_cnt2;
        if (rst_i) begin
            n_valid = 0; n_ctrl = '0; n_rs1 = 0; n_rs2 = 0; n_rd = 0; n_imm = 0; n_cnt = 0; n_cnt2 = 0;
        end else begin
            if (flush_i) n_valid = 0;
            else if (hz && adv) begin n_valid = 0; n_ctrl = '0; end
            else if (instr_valid_i && rdy) begin
                n_valid = 1; n_ctrl = c; n_rs1 = instr_i[19:15]; n_rs2 = instr_i[24:20];
                n_rd = c.reg_write ? instr_i[11:7] : 5'd0; n_imm = imm;
            end else if (m_valid && out_ready_i) n_valid = 0;
            if (hz && !flush_i) begin
                n_cnt  = (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
                n_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : m_cnt2;
            end
        end
        @(posedge clk_i);
        #1;
        if (rst_i) live = 1;
        m_valid = n_valid; m_ctrl = n_ctrl; m_rs1 = n_rs1; m_rs2 = n_rs2; m_rd = n_rd; m_imm = n_imm;
        m_cnt = n_cnt; m_cnt2 = n_cnt2;
    endtask

    task automatic drive(input bit v, input logic [31:0] ins, input bit fl, input bit exr,
                         input logic [4:0] exrd, input bit ordy);
        rst_i = 0; instr_valid_i = v; instr_i = ins; flush_i = fl;
        ex_mem_read_i = exr; ex_rd_i = exrd; out_ready_i = ordy;
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [6:0] opcs [9];
        opcs = '{OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC};
        w = $urandom;
        w[19:15] = 5'($urandom_range(0, 7));
        w[24:20] = 5'($urandom_range(0, 7));
        if ($urandom_range(0, 9) != 0) w[6:0] = opcs[$urandom_range(0, 8)];
        if (w[6:0] == OPC_STORE && w[14:12] > 3'd2) w[14:12] = 3'($urandom_range(0, 2));
        return w;
    endfunction

    initial begin
        step();
        step();
        chk("reset_valid", 64'(valid_o), 64'd0);
        chk("reset_ctrl", 64'(ctrl_o), 64'd0);
        chk("reset_rd", 64'(rd_o), 64'd0);
        chk("reset_imm", 64'(imm_o), 64'd0);
        chk("reset_cnt", 64'(stall_cnt_o), 64'd0);
        drive(1, ADD_3_1_2, 0, 0, 0, 1);
        step();
        chk("add_valid", 64'(valid_o), 64'd1);
        chk("add_reg_write", 64'(ctrl_o.reg_write), 64'd1);
        chk("add_alu_op", 64'(ctrl_o.alu_op), 64'b10);
        chk("add_rd", 64'(rd_o), 64'd3);
        drive(1, ADD_6_5_1, 0, 1, 5'd5, 1);
        chk("lu_in_ready", 64'(in_ready_o), 64'd0);
        step();
        chk("lu_bubble", 64'(valid_o), 64'd0);
        chk("lu_cnt", 64'(stall_cnt_o), 64'd1);
        drive(1, ADD_6_5_1, 0, 0, 0, 1);
        chk("lu_release", 64'(in_ready_o), 64'd1);
        step();
        chk("lu_issue_rd", 64'(rd_o), 64'd6);
        drive(1, SW_2_8_1, 0, 0, 0, 1);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(1, ADD_3_1_2, 0, 0, 0, 0);
            chk("bp_in_ready", 64'(in_ready_o), 64'd0);
            step();
            chk("bp_valid", 64'(valid_o), 64'd1);
            chk("bp_mem_write", 64'(ctrl_o.mem_write), 64'b1111);
            chk("bp_imm", 64'(imm_o), 64'd8);
        end
        drive(1, BEQ_1_2, 0, 0, 0, 1);
        step();
        chk("beq_imm", 64'(imm_o), 64'd16);
        drive(1, ADD_3_1_2, 1, 0, 0, 0);
        chk("flush_in_ready", 64'(in_ready_o), 64'd0);
        step();
        chk("flush_valid", 64'(valid_o), 64'd0);
        drive(0, ADD_3_1_2, 0, 0, 0, 1);
        step();
        chk("flush_nothing", 64'(valid_o), 64'd0);
        drive(1, 32'h0000_007F, 0, 0, 5'd0, 1);
        step();
        chk("ill_valid", 64'(valid_o), 64'd1);
        chk("ill_ctrl", 64'(ctrl_o), 64'd1);
        chk("ill_rd", 64'(rd_o), 64'd0);
        for (int i = 0; i < 5; i++) begin
            drive(1, ADD_6_5_1, 0, 1, 5'd5, 1);
            step();
        end
        chk("sat_cnt16", 64'(stall_cnt_o), 64'd6);
        chk("sat_cnt2", 64'(cnt2), 64'd3);
        for (int i = 0; i < 3000; i++) begin
            rst_i         = $urandom_range(0, 99) == 0;
            instr_valid_i = $urandom_range(0, 3) != 0;
            instr_i       = rand_instr();
            flush_i       = $urandom_range(0, 7) == 0;
            ex_mem_read_i = 1'($urandom_range(0, 1));
            ex_rd_i       = 5'($urandom_range(0, 7));
            out_ready_i   = $urandom_range(0, 3) != 0;
            step();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
